// File: rtl/md_defs.sv
// Shared encodings and default latencies for the multiply/divide unit.
package md_defs;
  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6
  } md_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
endpackage

// File: rtl/mdu.sv
// E-stage multiply/divide unit: owns HI/LO, computes on accept, commits after a
// fixed busy window so the stall unit can hold dependent MD instructions.
module mdu
  import md_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic        req,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  logic [CW-1:0] cnt;
  logic [31:0]   pend_hi, pend_lo;
  logic          pend_ok;

  logic          is_mul, is_div, accept;
  logic [63:0]   prod_s, prod_u;
  logic [31:0]   b_nz, q_s, r_s, q_u, r_u;
  logic          ovf;
  logic [31:0]   res_hi, res_lo;

  assign is_mul = (md_op == MD_MULT) || (md_op == MD_MULTU);
  assign is_div = (md_op == MD_DIV)  || (md_op == MD_DIVU);
  assign accept = !busy && !req;
  assign start  = accept && (is_mul || is_div);

  assign prod_s = $signed(A) * $signed(B);
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Divisor forced nonzero so the operator never sees /0; the result is dropped anyway.
  assign b_nz = (B == 32'd0) ? 32'd1 : B;
  assign ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  assign q_s  = ovf ? 32'h8000_0000 : 32'($signed(A) / $signed(b_nz));
  assign r_s  = ovf ? 32'd0         : 32'($signed(A) % $signed(b_nz));
  assign q_u  = A / b_nz;
  assign r_u  = A % b_nz;

  always_comb begin
    res_hi = prod_s[63:32];
    res_lo = prod_s[31:0];
    case (md_op)
      MD_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      MD_DIV:   begin res_hi = r_s;           res_lo = q_s;          end
      MD_DIVU:  begin res_hi = r_u;           res_lo = q_u;          end
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_ok <= 1'b0;
    end else if (busy) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        busy <= 1'b0;
        if (pend_ok) begin
          hi <= pend_hi;
          lo <= pend_lo;
        end
      end
    end else if (start) begin
      pend_hi <= res_hi;
      pend_lo <= res_lo;
      pend_ok <= !(is_div && (B == 32'd0));
      cnt     <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      busy    <= 1'b1;
    end else if (accept && md_op == MD_MTHI) begin
      hi <= A;
    end else if (accept && md_op == MD_MTLO) begin
      lo <= A;
    end
  end
endmodule
